// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared state enum, hold-counter width and default sizing for the round-robin lock arbiter.
package rr_arb_pkg;
   typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_e;
   localparam int HOLD_W = 8;
   localparam int NREQ_DEF = 3;
   localparam int MAX_HOLD_DEF = 8;
endpackage

// File: rtl/rr_lock_arbiter_if.sv
// rr_lock_arbiter_if: request/release/grant bundle between requesters (master) and the arbiter (slave).
interface rr_lock_arbiter_if
   import rr_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
);
   localparam int IW = $clog2(NREQ);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] done;
   logic [NREQ-1:0] gnt;
   logic gnt_vld;
   logic [IW-1:0] gnt_id;
   logic timeout;
   modport master (output req, done, input gnt, gnt_vld, gnt_id, timeout);
   modport slave (input req, done, output gnt, gnt_vld, gnt_id, timeout);
endinterface

// File: rtl/rr_prio_pick.sv
// rr_prio_pick: combinational round-robin pick, search starts after last and wraps so last ranks lowest.
module rr_prio_pick
   import rr_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   localparam int IW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] win,
   output logic [IW-1:0]   win_id,
   output logic            any
);
   always_comb begin
      win = '0;
      win_id = '0;
      any = |req;
      for (int k = NREQ; k >= 1; k--) begin
         if (req[(int'(last) + k) % NREQ]) begin
            win = '0;
            win[(int'(last) + k) % NREQ] = 1'b1;
            win_id = IW'((int'(last) + k) % NREQ);
         end
      end
   end
endmodule

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: locking round-robin arbiter; define RR_ARB_TIMEOUT_EN to force release after MAX_HOLD owned cycles.
module rr_lock_arbiter
   import rr_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input logic clk,
   input logic rst,
   rr_lock_arbiter_if.slave bus
);
   localparam int IW = $clog2(NREQ);
   arb_state_e state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0] id_q, id_d, last_q, last_d;
   logic to_q, to_d;
   logic [NREQ-1:0] win;
   logic [IW-1:0] win_id;
   logic any, rel, take, forced;
   rr_prio_pick #(.NREQ(NREQ)) u_pick (
      .req(bus.req),
      .last(last_q),
      .win(win),
      .win_id(win_id),
      .any(any)
   );
`ifdef RR_ARB_TIMEOUT_EN
   logic [HOLD_W-1:0] hold_q, hold_d;
   assign forced = (state_q == ARB_OWNED) && !bus.done[id_q] && (hold_q >= HOLD_W'(MAX_HOLD - 1));
   always_comb begin
      hold_d = take ? '0 : ((state_q == ARB_OWNED) && (hold_q != '1)) ? hold_q + 1'b1 : hold_q;
   end
   always_ff @(posedge clk) begin
      if (rst) hold_q <= '0;
      else hold_q <= hold_d;
   end
`else
   logic unused_max_hold;
   assign unused_max_hold = (MAX_HOLD > 0);
   assign forced = 1'b0;
`endif
   always_comb begin
      rel = (state_q == ARB_IDLE) || bus.done[id_q] || forced;
      take = rel && any;
      state_d = rel ? (any ? ARB_OWNED : ARB_IDLE) : state_q;
      gnt_d = rel ? win : gnt_q;
      id_d = rel ? win_id : id_q;
      last_d = take ? win_id : last_q;
      to_d = forced;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         gnt_q <= '0;
         id_q <= '0;
         last_q <= IW'(NREQ - 1);
         to_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q <= gnt_d;
         id_q <= id_d;
         last_q <= last_d;
         to_q <= to_d;
      end
   end
   assign bus.gnt = gnt_q;
   assign bus.gnt_vld = |gnt_q;
   assign bus.gnt_id = id_q;
   assign bus.timeout = to_q;
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter: directed scenarios plus random traffic checked against a behavioural ownership model.
module tb_rr_lock_arbiter;
   localparam int NREQ = 3;
   localparam int MAX_HOLD = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_vec = 0;
   int n_err = 0;
   int owner = -1;
   int last = NREQ - 1;
   int held = 0;
   bit to_exp = 1'b0;
   rr_lock_arbiter_if #(.NREQ(NREQ)) bus ();
   rr_lock_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask
   task automatic model_step(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] dn);
      bit rel;
      if (r) begin
         owner = -1;
         last = NREQ - 1;
         held = 0;
         to_exp = 1'b0;
         return;
      end
      to_exp = 1'b0;
      rel = (owner < 0) || dn[owner];
`ifdef RR_ARB_TIMEOUT_EN
      if (!rel && held >= MAX_HOLD) begin
         rel = 1'b1;
         to_exp = 1'b1;
      end
`endif
      if (!rel) begin
         held++;
         return;
      end
      owner = -1;
      for (int k = 1; k <= NREQ; k++) begin
         if (rq[(last + k) % NREQ]) begin
            owner = (last + k) % NREQ;
            last = owner;
            held = 1;
            break;
         end
      end
   endtask
   task automatic cyc(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] dn);
      logic [NREQ-1:0] g_exp;
      rst = r;
      bus.req = rq;
      bus.done = dn;
      @(posedge clk);
      model_step(r, rq, dn);
      @(negedge clk);
      g_exp = (owner < 0) ? '0 : NREQ'(1) << owner;
      chk("gnt", 32'(bus.gnt), 32'(g_exp));
      chk("gnt_vld", 32'(bus.gnt_vld), 32'(owner >= 0));
      chk("gnt_id", 32'(bus.gnt_id), (owner < 0) ? 32'd0 : 32'(owner));
      chk("timeout", 32'(bus.timeout), 32'(to_exp));
      chk("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      chk("vld_or", 32'(bus.gnt_vld), 32'(|bus.gnt));
      chk("id_cons", bus.gnt_vld ? (32'd1 << bus.gnt_id) : 32'd0, 32'(bus.gnt));
   endtask
   initial begin
      bus.req = '0;
      bus.done = '0;
      cyc(1, 3'b111, 3'b000);
      cyc(1, 3'b000, 3'b000);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      cyc(0, 3'b111, 3'b000);
      chk("rr_a", 32'(bus.gnt), 32'b001);
      cyc(0, 3'b111, 3'b001);
      chk("rr_b", 32'(bus.gnt), 32'b010);
      cyc(0, 3'b111, 3'b010);
      chk("rr_c", 32'(bus.gnt), 32'b100);
      cyc(0, 3'b111, 3'b100);
      chk("rr_d", 32'(bus.gnt), 32'b001);
      cyc(0, 3'b111, 3'b110);
      chk("ignore_done", 32'(bus.gnt), 32'b001);
      cyc(0, 3'b001, 3'b001);
      chk("regrant", 32'(bus.gnt), 32'b001);
      cyc(0, 3'b010, 3'b001);
      chk("own1", 32'(bus.gnt), 32'b010);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 3'b000, 3'b000);
         chk("lock_hold", 32'(bus.gnt), 32'b010);
      end
      cyc(0, 3'b000, 3'b010);
      chk("to_idle", 32'(bus.gnt), 32'd0);
      chk("to_idle_vld", 32'(bus.gnt_vld), 32'd0);
      cyc(0, 3'b100, 3'b000);
      chk("own2", 32'(bus.gnt), 32'b100);
`ifdef RR_ARB_TIMEOUT_EN
      for (int i = 0; i < 7; i++) begin
         cyc(0, 3'b101, 3'b000);
         chk("pre_to", 32'(bus.gnt), 32'b100);
      end
      cyc(0, 3'b101, 3'b000);
      chk("to_gnt", 32'(bus.gnt), 32'b001);
      chk("to_pulse", 32'(bus.timeout), 32'd1);
      cyc(0, 3'b101, 3'b000);
      chk("to_clear", 32'(bus.timeout), 32'd0);
`else
      for (int i = 0; i < 100; i++) begin
         cyc(0, 3'b101, 3'b000);
         chk("no_to", 32'(bus.gnt), 32'b100);
      end
      cyc(0, 3'b101, 3'b100);
      chk("rel2", 32'(bus.gnt), 32'b001);
`endif
      cyc(0, 3'b010, 3'b001);
      chk("pre_rst", 32'(bus.gnt), 32'b010);
      cyc(1, 3'b110, 3'b000);
      chk("rst_drop", 32'(bus.gnt), 32'd0);
      cyc(0, 3'b110, 3'b000);
      chk("ptr_reset", 32'(bus.gnt), 32'b010);
      for (int i = 0; i < 3000; i++) begin
         logic [NREQ-1:0] rq, dn;
         rq = NREQ'($urandom);
         dn = '0;
         for (int b = 0; b < NREQ; b++) dn[b] = ($urandom_range(0, 3) == 0);
         cyc(($urandom_range(0, 199) == 0), rq, dn);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/rr_lock_arbiter.md
RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters, 2..16.
REQ-002 Parameter MAX_HOLD, default 8: maximum cycles one grant may be held (timeout build only), 2..255.
REQ-003 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port req, input, NREQ: per-requester request level.
REQ-006 Port done, input, NREQ: per-requester release pulse; only the current owner's bit is honoured.
REQ-007 Port gnt, output, NREQ: registered one-hot grant, all-zero when idle.
REQ-008 Port gnt_vld, output, 1: OR of gnt.
REQ-009 Port gnt_id, output, $clog2(NREQ): index of the owner, 0 when idle.
REQ-010 Port timeout, output, 1: one-cycle pulse on forced release (timeout build only, else tied 0).

Function
REQ-011 Two states: IDLE (no owner) and OWNED (exactly one gnt bit set); gnt never has more than one bit set.
REQ-012 Priority pointer last = index of most recent owner; the search starts at last+1 mod NREQ and wraps, so the last owner ranks lowest.
REQ-013 IDLE: if req != 0 at edge N, gnt = winner from edge N (visible cycle N+1), state OWNED; else stay IDLE, gnt = 0.
REQ-014 OWNED: grant held while done[owner] = 0; req[owner] deasserting does not release the grant.
REQ-015 done[owner] = 1 at edge N: arbitration over req sampled at edge N, excluding nothing; a winner becomes owner at N+1 with no idle gap; if req = 0 -> IDLE, gnt = 0 at N+1.
REQ-016 If only the releasing owner still requests, it is re-granted (back-to-back).
REQ-017 done bits of non-owners and done while IDLE are ignored.
REQ-018 last updates only when a new grant is issued, to the new owner index.
REQ-019 Hold counter (8 bits) clears on every new grant and increments each OWNED cycle; it saturates and never wraps.

Reset
REQ-020 While rst = 1 at an edge: state IDLE, gnt = 0, gnt_vld = 0, gnt_id = 0, timeout = 0, hold counter 0, last = NREQ-1 (requester 0 highest priority after reset).
REQ-021 Reset mid-grant drops the grant in the following cycle regardless of done; req is not sampled during reset.

Configuration
REQ-022 Macro RR_ARB_TIMEOUT_EN defined: if the hold counter reaches MAX_HOLD-1 without done[owner], the next edge performs a release identical to REQ-015 and pulses timeout for one cycle.
REQ-023 Macro RR_ARB_TIMEOUT_EN undefined: no forced release; a grant is held indefinitely until done[owner]; timeout is constant 0; the hold counter is not built.
REQ-024 done[owner] at the same edge as the timeout condition counts as a normal release; timeout stays 0.

Structure
REQ-025 Package rr_arb_pkg holds the state enum (ARB_IDLE, ARB_OWNED), the hold-counter width constant and the default NREQ/MAX_HOLD values.
REQ-026 Combinational sub-module rr_prio_pick (inputs req, last; outputs one-hot winner, winner index, any) implements REQ-012 and is instantiated once.

Verification (NREQ=3, MAX_HOLD=8)
REQ-027 After reset, req=3'b111 -> gnt=001 next cycle; done[0] pulsed -> gnt=010 next cycle; done[1] -> gnt=100; done[2] -> gnt=001.
REQ-028 Owner 1 granted, req=3'b010 dropped to 000 while done=0 for 5 cycles -> gnt stays 010; then done[1] with req=000 -> gnt=000, gnt_vld=0.
REQ-029 Owner 0, done=3'b110 pulsed -> ignored, gnt stays 001; done=3'b001 with req=001 -> gnt=001 re-granted without a gap.
REQ-030 Timeout build: owner 2 holds with no done -> at the 8th OWNED cycle the release edge occurs; timeout=1 for one cycle; req=101 -> gnt=001. Non-timeout build: gnt stays 100 for 100 cycles.
REQ-031 rst asserted while gnt=010 -> gnt=000 next cycle; after rst released with req=110 -> gnt=010 (pointer reset to 2).
REQ-032 Bench checks every cycle: gnt one-hot or zero, gnt_vld=|gnt, gnt_id consistent with gnt.
